// File: rtl/hdlverifier_trigger_unit.sv
// Trigger-condition evaluator feeding the capture core.
// A two-stage sample pipeline (s1 = current, s2 = previous) evaluates per-signal
// level and edge conditions. The trigger fires on the (occ+1)-th qualifying sample
// seen while armed. Because the pipeline is two stages deep, the trigger lines up
// with the core's 2-cycle data delay.
module hdlverifier_trigger_unit #(
  parameter int unsigned SIG_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH  = 9,
  parameter int unsigned TRIG_WIDTH = 3 * SIG_WIDTH + 1 + CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [SIG_WIDTH-1:0]  trig_signal,
  input  logic [TRIG_WIDTH-1:0] trigger_setting,
  input  logic                  start,
  output logic                  trigger,
  output logic                  armed,
  output logic [CNT_WIDTH-1:0]  hit_count
);

  // Field positions inside the setting word
  localparam int unsigned CombBit = 3 * SIG_WIDTH;
  localparam int unsigned OccLsb  = 3 * SIG_WIDTH + 1;

  // Per-signal condition codes; 110/111 fall through to don't-care
  localparam logic [2:0] CondLow     = 3'b001;
  localparam logic [2:0] CondHigh    = 3'b010;
  localparam logic [2:0] CondRise    = 3'b011;
  localparam logic [2:0] CondFall    = 3'b100;
  localparam logic [2:0] CondAnyEdge = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StTriggered
  } state_e;

  state_e                state_q, state_d;
  logic [SIG_WIDTH-1:0]  s1_q, s2_q;
  logic [TRIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic                  trigger_q, trigger_d;
  logic                  armed_q, armed_d;

  logic [SIG_WIDTH-1:0]  term_act;
  logic [SIG_WIDTH-1:0]  term_val;
  logic                  and_match, or_match, match;
  logic [CNT_WIDTH-1:0]  occ;

  assign occ = shadow_q[TRIG_WIDTH-1:OccLsb];

  // Sample pipeline: only advances on enabled cycles, independent of FSM state so
  // that edge terms can use history captured before arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (clk_enable) begin
      s1_q <= trig_signal;
      s2_q <= s1_q;
    end
  end

  // Per-signal term evaluation against the latched settings
  always_comb begin
    term_act = '0;
    term_val = '0;
    for (int i = 0; i < SIG_WIDTH; i++) begin
      case (shadow_q[3*i +: 3])
        CondLow: begin
          term_act[i] = 1'b1;
          term_val[i] = ~s1_q[i];
        end
        CondHigh: begin
          term_act[i] = 1'b1;
          term_val[i] = s1_q[i];
        end
        CondRise: begin
          term_act[i] = 1'b1;
          term_val[i] = s1_q[i] & ~s2_q[i];
        end
        CondFall: begin
          term_act[i] = 1'b1;
          term_val[i] = ~s1_q[i] & s2_q[i];
        end
        CondAnyEdge: begin
          term_act[i] = 1'b1;
          term_val[i] = s1_q[i] ^ s2_q[i];
        end
        default: begin
          term_act[i] = 1'b0;
          term_val[i] = 1'b0;
        end
      endcase
    end
  end

  // Combine active terms; inactive terms are neutral for AND (1) and OR (0), so an
  // all-don't-care setting matches always under AND and never under OR.
  always_comb begin
    and_match = 1'b1;
    or_match  = 1'b0;
    for (int i = 0; i < SIG_WIDTH; i++) begin
      if (term_act[i]) begin
        and_match = and_match & term_val[i];
        or_match  = or_match | term_val[i];
      end
    end
    match = shadow_q[CombBit] ? or_match : and_match;
  end

  // Next-state logic: start=0 always returns to idle and wins over a match
  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StArmed;
          hit_d    = '0;
          shadow_d = trigger_setting;
        end
      end
      StArmed: begin
        if (!start) begin
          state_d = StIdle;
        end else if (clk_enable && match) begin
          if (hit_q == occ) begin
            state_d = StTriggered;
          end else begin
            hit_d = hit_q + CNT_WIDTH'(1);
          end
        end
      end
      StTriggered: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    trigger_d = (state_d == StTriggered);
    armed_d   = (state_d == StArmed);
  end

  // State, counter, shadow settings and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hit_q     <= '0;
      shadow_q  <= '0;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      shadow_q  <= shadow_d;
      trigger_q <= trigger_d;
      armed_q   <= armed_d;
    end
  end

  assign trigger   = trigger_q;
  assign armed     = armed_q;
  assign hit_count = hit_q;

endmodule
